lockin_mux_demod: RTL and testbench
===================================

LOCKIN_MUX_DEMOD -- requirements
Module: lockin_mux_demod

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of demodulated channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 24, signed sample and output width.
REQ-003 SHALL have parameter DECIM_LOG2, default 7, log2 of samples accumulated per output block.
REQ-004 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port tick_i  input  1  one-cycle pulse, new sample set valid.
REQ-007 SHALL have port sig_i  input  NUM_CH*DATA_W  packed signed channel samples, ch0 in LSBs.
REQ-008 SHALL have port sin_i  input  DATA_W  signed in-phase reference.
REQ-009 SHALL have port cos_i  input  DATA_W  signed quadrature reference.
REQ-010 SHALL have port clr_ovr_i  input  1  clears overrun_o.
REQ-011 SHALL have port i_o  output  NUM_CH*DATA_W  packed signed in-phase results.
REQ-012 SHALL have port q_o  output  NUM_CH*DATA_W  packed signed quadrature results.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse, i_o/q_o updated.
REQ-014 SHALL have port overrun_o  output  1  sticky, tick_i arrived while busy.
REQ-015 SHALL have port count_o  output  32  unsigned completed-block counter.

Function
REQ-016 SHALL use one shared signed DATA_W x DATA_W multiplier, time-multiplexed over all channels.
REQ-017 SHALL implement FSM states IDLE, MAC, DUMP.
REQ-018 IDLE + tick_i at cycle t: SHALL latch sig_i, sin_i, cos_i; enter MAC at t+1.
REQ-019 MAC SHALL last exactly 2*NUM_CH cycles: ch k x sin at step 2k, ch k x cos at step 2k+1, each added to its accumulator.
REQ-020 After MAC, SHALL increment sample index; if index wraps from 2^DECIM_LOG2-1 to 0 enter DUMP, else IDLE.
REQ-021 DUMP SHALL load i_o/q_o from accumulators, clear accumulators, pulse done_o, increment count_o, return to IDLE; done_o high at cycle t+2*NUM_CH+1 of the final tick.
REQ-022 Accumulators SHALL be 2*DATA_W+DECIM_LOG2 bits signed; no accumulator overflow possible.
REQ-023 Output SHALL be accumulator arithmetically shifted right by DATA_W+DECIM_LOG2-1, reduced to DATA_W bits per REQ-031.
REQ-024 tick_i in MAC or DUMP SHALL be ignored (sample dropped, index unchanged) and set overrun_o next cycle.
REQ-025 clr_ovr_i SHALL clear overrun_o next cycle; simultaneous clr_ovr_i and overrun event: overrun_o SHALL end set.
REQ-026 count_o SHALL wrap 0xFFFFFFFF -> 0.
REQ-027 i_o/q_o SHALL hold between done_o pulses.

Reset
REQ-028 reset_i SHALL override all other inputs: FSM to IDLE, sample index 0, accumulators 0.
REQ-029 Outputs after reset SHALL be i_o=0, q_o=0, done_o=0, overrun_o=0, count_o=0.
REQ-030 Reset mid-MAC or mid-block SHALL discard partial block; next block SHALL take a full 2^DECIM_LOG2 samples.

Configuration
REQ-031 With LOCKIN_SAT_EN defined, output SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; without it, SHALL keep the low DATA_W bits (two's-complement wrap).

Structure
REQ-032 Package lockin_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-033 Sub-module lockin_mac SHALL contain the multiplier, accumulator bank, and shift/saturate logic; FSM and counters SHALL stay in lockin_mux_demod.

Verification (NUM_CH=2, DATA_W=24, DECIM_LOG2=2)
REQ-034 4 ticks, sig=0x400000 both ch, sin=0x400000, cos=0 -> one done_o, i_o each ch=0x200000, q_o=0, count_o=1.
REQ-035 4 ticks, sig=-0x800000, sin=-0x800000 -> i_o=0x7FFFFF with LOCKIN_SAT_EN, 0x800000 without.
REQ-036 tick at t and t+2 -> second ignored, overrun_o=1 from t+3; block completes only after 4 accepted ticks; clr_ovr_i -> overrun_o=0.
REQ-037 tick spacing 6 cycles -> done_o exactly 5 cycles after 4th tick, no overrun.
REQ-038 reset_i during 3rd tick's MAC, then 4 ticks sig=0x400000, sin=0x400000 -> i_o=0x200000 after 4th tick, count_o=1.
REQ-039 count_o preloaded by forcing 0xFFFFFFFF, one block -> count_o=0.

Source files
------------

// File: rtl/lockin_pkg.sv
// lockin_pkg: shared FSM state type and default parameters for the lock-in demodulator.
package lockin_pkg;
    typedef enum logic [1:0] {IDLE, MAC, DUMP} state_t;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DATA_W     = 24;
    localparam int DEF_DECIM_LOG2 = 7;
endpackage

// File: rtl/lockin_mac.sv
// lockin_mac: shared multiplier, I/Q accumulator bank and output scaling.
// Define LOCKIN_SAT_EN to saturate outputs instead of keeping the low DATA_W bits.
module lockin_mac
    import lockin_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DECIM_LOG2 = DEF_DECIM_LOG2,
    parameter int SW         = 3
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        i_en,
    input  logic                        i_dump,
    input  logic [SW-1:0]               i_step,
    input  logic [NUM_CH*DATA_W-1:0]    i_sig,
    input  logic signed [DATA_W-1:0]    i_sin,
    input  logic signed [DATA_W-1:0]    i_cos,
    output logic [NUM_CH*DATA_W-1:0]    o_i,
    output logic [NUM_CH*DATA_W-1:0]    o_q
);
    localparam int AW = 2 * DATA_W + DECIM_LOG2;
    localparam int PW = 2 * DATA_W;
    localparam int SH = DATA_W + DECIM_LOG2 - 1;
`ifdef LOCKIN_SAT_EN
    localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;
`endif

    logic signed [AW-1:0]     r_acc_i [NUM_CH];
    logic signed [AW-1:0]     r_acc_q [NUM_CH];
    logic signed [DATA_W-1:0] r_i [NUM_CH];
    logic signed [DATA_W-1:0] r_q [NUM_CH];
    logic signed [DATA_W-1:0] w_a, w_b;
    logic signed [PW-1:0]     w_prod;

    function automatic logic signed [DATA_W-1:0] reduce(input logic signed [AW-1:0] a);
`ifdef LOCKIN_SAT_EN
        logic signed [AW-1:0] s;
        s = a >>> SH;
        return (s > MAXV) ? DATA_W'(MAXV) : (s < MINV) ? DATA_W'(MINV) : DATA_W'(s);
`else
        return DATA_W'(a >>> SH);
`endif
    endfunction

    // even steps use the in-phase reference, odd steps the quadrature one
    always_comb begin
        w_a = '0;
        for (int c = 0; c < NUM_CH; c++)
            if ((i_step >> 1) == SW'(c)) w_a = i_sig[c*DATA_W +: DATA_W];
        w_b = i_step[0] ? i_cos : i_sin;
        w_prod = PW'(w_a) * PW'(w_b);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc_i[c] <= '0;
                r_acc_q[c] <= '0;
                r_i[c]     <= '0;
                r_q[c]     <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (i_dump) begin
                    r_i[c]     <= reduce(r_acc_i[c]);
                    r_q[c]     <= reduce(r_acc_q[c]);
                    r_acc_i[c] <= '0;
                    r_acc_q[c] <= '0;
                end else if (i_en && i_step == SW'(2*c)) begin
                    r_acc_i[c] <= r_acc_i[c] + AW'(w_prod);
                end else if (i_en && i_step == SW'(2*c+1)) begin
                    r_acc_q[c] <= r_acc_q[c] + AW'(w_prod);
                end
            end
        end
    end

    // results are presented during the dump cycle itself so they line up with done_o
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign o_i[g*DATA_W +: DATA_W] = i_dump ? reduce(r_acc_i[g]) : r_i[g];
        assign o_q[g*DATA_W +: DATA_W] = i_dump ? reduce(r_acc_q[g]) : r_q[g];
    end
endmodule

// File: rtl/lockin_mux_demod.sv
// lockin_mux_demod: time-multiplexed multi-channel lock-in I/Q demodulator with block decimation.
// Define LOCKIN_SAT_EN to saturate outputs instead of wrapping.
module lockin_mux_demod
    import lockin_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DECIM_LOG2 = DEF_DECIM_LOG2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        tick_i,
    input  logic [NUM_CH*DATA_W-1:0]    sig_i,
    input  logic signed [DATA_W-1:0]    sin_i,
    input  logic signed [DATA_W-1:0]    cos_i,
    input  logic                        clr_ovr_i,
    output logic [NUM_CH*DATA_W-1:0]    i_o,
    output logic [NUM_CH*DATA_W-1:0]    q_o,
    output logic                        done_o,
    output logic                        overrun_o,
    output logic [31:0]                 count_o
);
    localparam int SW = $clog2(2 * NUM_CH);

    state_t                    r_state, w_next;
    logic [SW-1:0]             r_step;
    logic [DECIM_LOG2-1:0]     r_idx;
    logic [NUM_CH*DATA_W-1:0]  r_sig;
    logic signed [DATA_W-1:0]  r_sin, r_cos;
    logic                      r_ovr;
    logic [31:0]               r_count;
    logic                      w_last, w_wrap;

    always_comb begin
        w_next = r_state;
        w_last = r_step == SW'(2*NUM_CH-1);
        w_wrap = &r_idx;
        if (r_state == IDLE && tick_i) w_next = MAC;
        if (r_state == MAC && w_last) w_next = w_wrap ? DUMP : IDLE;
        if (r_state == DUMP) w_next = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_idx   <= '0;
            r_sig   <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_ovr   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_step  <= (r_state == MAC && !w_last) ? r_step + SW'(1) : '0;
            if (r_state == IDLE && tick_i) begin
                r_sig <= sig_i;
                r_sin <= sin_i;
                r_cos <= cos_i;
            end
            if (r_state == MAC && w_last) r_idx <= r_idx + DECIM_LOG2'(1);
            // a new overrun wins over a simultaneous clear
            r_ovr <= (tick_i && r_state != IDLE) || (r_ovr && !clr_ovr_i);
            if (r_state == DUMP) r_count <= r_count + 32'd1;
        end
    end

    assign done_o    = r_state == DUMP;
    assign overrun_o = r_ovr;
    assign count_o   = r_count;

    lockin_mac #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DECIM_LOG2(DECIM_LOG2), .SW(SW)
    ) u_mac (
        .clk_i(clk_i), .reset_i(reset_i),
        .i_en(r_state == MAC), .i_dump(r_state == DUMP), .i_step(r_step),
        .i_sig(r_sig), .i_sin(r_sin), .i_cos(r_cos),
        .o_i(i_o), .o_q(q_o)
    );
endmodule

// File: tb/tb_lockin_mux_demod.sv
// tb_lockin_mux_demod: directed and random checks against a block-level behavioural model.
module tb_lockin_mux_demod;
    logic        clk = 0, rst = 1, tick = 0, clr = 0, preload = 0, run = 0;
    logic [47:0] sig = 0;
    logic [23:0] sin = 0, cos = 0;
    logic [47:0] i_o, q_o;
    logic        done, ovr;
    logic [31:0] count;

    lockin_mux_demod #(.NUM_CH(2), .DATA_W(24), .DECIM_LOG2(2)) dut (
        .clk_i(clk), .reset_i(rst), .tick_i(tick), .sig_i(sig), .sin_i(sin), .cos_i(cos),
        .clr_ovr_i(clr), .i_o(i_o), .q_o(q_o), .done_o(done), .overrun_o(ovr), .count_o(count)
    );

    always #5 clk = ~clk;

`ifdef LOCKIN_SAT_EN
    localparam logic [23:0] BIGV = 24'h7FFFFF;
`else
    localparam logic [23:0] BIGV = 24'h800000;
`endif

    // model: ticks are accepted only when no block work is pending; every 4th accepted
    // sample closes a block whose result appears 2*NUM_CH+1 cycles after that tick
    longint      si [2] = '{0, 0};
    longint      sq [2] = '{0, 0};
    logic [47:0] pi = 0, pq = 0, exp_i = 0, exp_q = 0;
    int          m_b = 0, m_cd = 0, m_n = 0;
    logic        m_done = 0, m_ovr = 0;
    logic [31:0] m_count = 0;

    function automatic logic [23:0] red(input longint s);
        longint v;
        v = s >>> 25;
`ifdef LOCKIN_SAT_EN
        if (v > 8388607) v = 8388607;
        if (v < -8388608) v = -8388608;
`endif
        return v[23:0];
    endfunction

    always @(posedge clk) begin : model
        bit busy;
        longint a, ps, pc;
        if (rst) begin
            m_b = 0; m_cd = 0; m_n = 0; m_done = 0; m_ovr = 0; m_count = 0;
            exp_i = 0; exp_q = 0;
            for (int c = 0; c < 2; c++) begin si[c] = 0; sq[c] = 0; end
        end else begin
            if (m_done) m_count = m_count + 1;
            if (preload) m_count = 32'hFFFFFFFF;
            busy = m_b > 0;
            if (m_b > 0) m_b--;
            if (m_cd > 0) m_cd--;
            m_ovr = (tick && busy) ? 1'b1 : clr ? 1'b0 : m_ovr;
            if (tick && !busy) begin
                ps = $signed(sin);
                pc = $signed(cos);
                for (int c = 0; c < 2; c++) begin
                    a = $signed(sig[c*24 +: 24]);
                    si[c] += a * ps;
                    sq[c] += a * pc;
                end
                m_n++;
                if (m_n == 4) begin
                    for (int c = 0; c < 2; c++) begin
                        pi[c*24 +: 24] = red(si[c]);
                        pq[c*24 +: 24] = red(sq[c]);
                        si[c] = 0;
                        sq[c] = 0;
                    end
                    m_n = 0; m_b = 5; m_cd = 5;
                end else m_b = 4;
            end
            m_done = m_cd == 1;
            if (m_done) begin exp_i = pi; exp_q = pq; end
        end
    end

    int          n_vec = 0, n_bad = 0;
    logic        lit_en = 0, lit_done = 0, lit_ovr = 0;
    logic [4:0]  lit_m = 0;
    logic [47:0] lit_i = 0, lit_q = 0;
    logic [31:0] lit_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("done", 64'(done), 64'(m_done));
        chk("overrun", 64'(ovr), 64'(m_ovr));
        chk("count", 64'(count), 64'(m_count));
        chk("i_o", 64'(i_o), 64'(exp_i));
        chk("q_o", 64'(q_o), 64'(exp_q));
        if (lit_en) begin
            if (lit_m[0]) begin chk("lit_i", 64'(i_o), 64'(lit_i)); chk("model_i", 64'(exp_i), 64'(lit_i)); end
            if (lit_m[1]) begin chk("lit_q", 64'(q_o), 64'(lit_q)); chk("model_q", 64'(exp_q), 64'(lit_q)); end
            if (lit_m[2]) begin chk("lit_count", 64'(count), 64'(lit_cnt)); chk("model_count", 64'(m_count), 64'(lit_cnt)); end
            if (lit_m[3]) begin chk("lit_done", 64'(done), 64'(lit_done)); chk("model_done", 64'(m_done), 64'(lit_done)); end
            if (lit_m[4]) begin chk("lit_ovr", 64'(ovr), 64'(lit_ovr)); chk("model_ovr", 64'(m_ovr), 64'(lit_ovr)); end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic lit(input logic [4:0] m, input logic [47:0] li, input logic [47:0] lq,
                       input logic [31:0] lc, input logic ld, input logic lo);
        lit_m = m; lit_i = li; lit_q = lq; lit_cnt = lc; lit_done = ld; lit_ovr = lo;
        lit_en = 1;
        cyc(1);
        lit_en = 0;
    endtask

    task automatic set_in(input logic [23:0] s, input logic [23:0] sn, input logic [23:0] cs);
        sig = {s, s}; sin = sn; cos = cs;
    endtask

    task automatic pulse();
        tick = 1; cyc(1); tick = 0;
    endtask

    task automatic blk(input int k);
        repeat (k) begin pulse(); cyc(5); end
    endtask

    task automatic do_reset();
        rst = 1; cyc(2); rst = 0;
    endtask

    function automatic logic [23:0] rv();
        return ($urandom_range(0, 7) == 0) ? 24'h800000 : 24'($urandom);
    endfunction

    initial begin
        cyc(1);
        run = 1;
        cyc(2);
        rst = 0;
        lit(5'b11111, 48'h0, 48'h0, 32'd0, 1'b0, 1'b0);
        // positive full-scale-half block
        set_in(24'h400000, 24'h400000, 24'h0);
        blk(4);
        lit(5'b00111, {2{24'h200000}}, 48'h0, 32'd1, 1'b0, 1'b0);
        // done lands 5 cycles after the closing tick
        blk(3);
        pulse();
        cyc(3);
        lit(5'b11000, 48'h0, 48'h0, 32'd0, 1'b1, 1'b0);
        cyc(2);
        // most-negative squared: wrap or saturate
        do_reset();
        set_in(24'h800000, 24'h800000, 24'h0);
        blk(4);
        lit(5'b00111, {2{BIGV}}, 48'h0, 32'd1, 1'b0, 1'b0);
        // dropped tick during MAC raises overrun and does not count
        do_reset();
        set_in(24'h400000, 24'h400000, 24'h400000);
        pulse();
        lit(5'b10000, 48'h0, 48'h0, 32'd0, 1'b0, 1'b0);
        tick = 1;
        lit(5'b10000, 48'h0, 48'h0, 32'd0, 1'b0, 1'b1);
        tick = 0;
        cyc(3);
        blk(2);
        lit(5'b01100, 48'h0, 48'h0, 32'd0, 1'b0, 1'b0);
        blk(1);
        lit(5'b10111, {2{24'h200000}}, {2{24'h200000}}, 32'd1, 1'b0, 1'b1);
        clr = 1; cyc(1); clr = 0;
        lit(5'b10000, 48'h0, 48'h0, 32'd0, 1'b0, 1'b0);
        // reset mid-MAC discards the partial block
        set_in(24'h400000, 24'h400000, 24'h0);
        blk(2);
        pulse();
        cyc(1);
        do_reset();
        cyc(3);
        blk(3);
        lit(5'b00100, 48'h0, 48'h0, 32'd0, 1'b0, 1'b0);
        blk(1);
        lit(5'b00111, {2{24'h200000}}, 48'h0, 32'd1, 1'b0, 1'b0);
        // counter wrap
        force dut.r_count = 32'hFFFFFFFF;
        preload = 1;
        cyc(1);
        release dut.r_count;
        preload = 0;
        lit(5'b00100, 48'h0, 48'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        blk(4);
        lit(5'b00100, 48'h0, 48'h0, 32'd0, 1'b0, 1'b0);
        // random traffic
        do_reset();
        repeat (1500) begin
            rst  = $urandom_range(0, 299) == 0;
            tick = $urandom_range(0, 2) == 0;
            clr  = $urandom_range(0, 19) == 0;
            sig  = {rv(), rv()};
            sin  = rv();
            cos  = rv();
            cyc(1);
        end
        rst = 0; tick = 0; clr = 0;
        cyc(8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
